boot_rom_arbiter: RTL and testbench

Shares the single SoC boot ROM port between NB_REQ TCDM-style requesters (e.g. FC instruction fetch, FC data, debug module). It arbitrates round-robin, forwards one read per cycle to the ROM with fixed 1-cycle response latency, and routes the response back to the winning requester. Writes and out-of-range addresses are answered locally with an error and are never forwarded to the ROM. It sits between the SoC interconnect and the boot ROM macro/autogen wrapper.

---
 rtl/boot_rom_arb_pkg.sv | 15 +
 rtl/boot_rom_rr_arb.sv | 64 ++++++
 rtl/boot_rom_arbiter.sv | 102 ++++++++++
 tb/tb_boot_rom_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_rom_arb_pkg.sv
// Shared types and constants for the boot ROM arbiter.
//   BOOT_ROM_ERR_RDATA : data returned with an error response
//   resp_t             : response register contents (valid, error flag, owner index)
package boot_rom_arb_pkg;

    localparam logic [31:0] BOOT_ROM_ERR_RDATA = 32'h0;

    // owner is 3 bits wide so that up to 8 requesters can be encoded.
    typedef struct packed {
        logic       valid;
        logic       err;
        logic [2:0] owner;
    } resp_t;

endpackage

// File: rtl/boot_rom_rr_arb.sv
// Round-robin one-hot arbiter with a registered priority pointer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector
//   gnt_o         : one-hot grant, combinational from req_i
//   idx_o         : index of the granted requester
//   valid_o       : a grant was issued this cycle
module boot_rom_rr_arb #(
    parameter int NB_REQ = 2,
    parameter int IDX_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NB_REQ-1:0] req_i,
    output logic [NB_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);

    // One extra bit so ptr + offset can exceed NB_REQ-1 before the wrap.
    localparam int            CW       = IDX_W + 1;
    localparam logic [CW-1:0] NB_REQ_C = CW'(NB_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]    cand;
    logic             found;

    // Scan starts at the pointer and wraps; first asserted request wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= NB_REQ_C) begin
                cand = cand - NB_REQ_C;
            end
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx_o = cand[IDX_W-1:0];
            end
        end
        if (found) begin
            gnt_o[idx_o] = 1'b1;
        end
        valid_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (idx_o == IDX_W'(NB_REQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares the boot ROM port between NB_REQ TCDM-style requesters.
// One access is granted per cycle (round-robin); reads inside the ROM window
// go to the ROM, writes and out-of-range accesses are answered locally with
// an error. Responses appear exactly one cycle after the grant.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i/add_i/wen_i : requester side (wen_i = 1 means read)
//   gnt_o         : combinational one-hot grant
//   r_valid_o     : one-hot response valid, cycle after grant
//   r_rdata_o     : shared response data (0 on error or idle)
//   r_opc_o       : response error flag
//   rom_req_o/rom_addr_o/rom_rdata_i : ROM macro port (1-cycle read latency)
module boot_rom_arbiter
    import boot_rom_arb_pkg::*;
#(
    parameter int          NB_REQ         = 2,
    parameter int          ROM_ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR      = 32'h1A00_0000
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NB_REQ-1:0]             req_i,
    input  logic [NB_REQ-1:0][31:0]       add_i,
    input  logic [NB_REQ-1:0]             wen_i,
    output logic [NB_REQ-1:0]             gnt_o,
    output logic [NB_REQ-1:0]             r_valid_o,
    output logic [31:0]                   r_rdata_o,
    output logic                          r_opc_o,
    output logic                          rom_req_o,
    output logic [ROM_ADDR_WIDTH-3:0]     rom_addr_o,
    input  logic [31:0]                   rom_rdata_i
);

    localparam int          IDX_W    = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    // 33 bits so a full 32-bit ROM window still has a representable size.
    localparam logic [32:0] ROM_SIZE = 33'(1) << ROM_ADDR_WIDTH;

    logic [IDX_W-1:0] win_idx;
    logic             any_gnt;
    logic [31:0]      win_add;
    logic             win_wen;
    logic [31:0]      offset;
    logic             in_range;
    logic             fwd;

    resp_t resp_q, resp_d;

    boot_rom_rr_arb #(
        .NB_REQ (NB_REQ),
        .IDX_W  (IDX_W)
    ) i_rr_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .idx_o   (win_idx),
        .valid_o (any_gnt)
    );

    // Classification of the winner. A wrap-around subtract turns addresses
    // below BASE_ADDR into huge offsets, so one unsigned compare covers both
    // sides of the window.
    always_comb begin
        win_add  = add_i[win_idx];
        win_wen  = wen_i[win_idx];
        offset   = win_add - BASE_ADDR;
        in_range = ({1'b0, offset} < ROM_SIZE);
        fwd      = in_range & win_wen;
    end

    // Byte offset bits [1:0] are dropped: unaligned reads return the word.
    assign rom_req_o  = any_gnt & fwd;
    assign rom_addr_o = offset[ROM_ADDR_WIDTH-1:2];

    // Owner and error flag are only refreshed on a grant; valid alone gates them.
    always_comb begin
        resp_d       = resp_q;
        resp_d.valid = any_gnt;
        if (any_gnt) begin
            resp_d.err   = ~fwd;
            resp_d.owner = 3'(win_idx);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    // Read data comes straight from the ROM in the response cycle.
    always_comb begin
        r_valid_o = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            r_valid_o[k] = resp_q.valid && (resp_q.owner == 3'(k));
        end
        r_opc_o   = resp_q.valid & resp_q.err;
        r_rdata_o = (resp_q.valid && !resp_q.err) ? rom_rdata_i : BOOT_ROM_ERR_RDATA;
    end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
module tb_boot_rom_arbiter;

    localparam int          NB   = 2;
    localparam logic [31:0] BASE = 32'h1A00_0000;

    logic             clk_i;
    logic             rst_ni;
    logic [1:0]       req_i;
    logic [1:0][31:0] add_i;
    logic [1:0]       wen_i;
    logic [1:0]       gnt_o;
    logic [1:0]       r_valid_o;
    logic [31:0]      r_rdata_o;
    logic             r_opc_o;
    logic             rom_req_o;
    logic [10:0]      rom_addr_o;
    logic [31:0]      rom_rdata_i;

    boot_rom_arbiter #(
        .NB_REQ         (NB),
        .ROM_ADDR_WIDTH (13),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .add_i       (add_i),
        .wen_i       (wen_i),
        .gnt_o       (gnt_o),
        .r_valid_o   (r_valid_o),
        .r_rdata_o   (r_rdata_o),
        .r_opc_o     (r_opc_o),
        .rom_req_o   (rom_req_o),
        .rom_addr_o  (rom_addr_o),
        .rom_rdata_i (rom_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ROM macro model: data for an enabled read appears the next cycle;
    // otherwise the bus carries garbage that the DUT must mask.
    logic [31:0] mem [2048];
    always @(posedge clk_i) begin
        rom_rdata_i <= rom_req_o ? mem[rom_addr_o] : $urandom;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          ptr_m;
    logic        pend_valid;
    int          pend_owner;
    logic        pend_err;
    logic [31:0] pend_data;

    // Expectations for the cycle currently driven
    int          e_w;
    logic [1:0]  e_gnt;
    logic        e_fwd;
    logic        e_rom_req;
    logic [10:0] e_addr;
    logic [1:0]  e_rv;
    logic        e_opc;
    logic [31:0] e_rdata;

    function automatic void model_reset();
        ptr_m      = 0;
        pend_valid = 1'b0;
        pend_owner = 0;
        pend_err   = 1'b0;
        pend_data  = '0;
    endfunction

    task automatic apply(input logic [1:0] r, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [1:0] w);
        logic [31:0] off;
        req_i    = r;
        add_i[0] = a0;
        add_i[1] = a1;
        wen_i    = w;
        e_w = -1;
        for (int k = 0; k < NB; k++) begin
            int c;
            c = (ptr_m + k) % NB;
            if (e_w < 0 && r[c]) e_w = c;
        end
        e_gnt     = '0;
        e_fwd     = 1'b0;
        e_rom_req = 1'b0;
        e_addr    = '0;
        if (e_w >= 0) begin
            e_gnt[e_w] = 1'b1;
            off        = ((e_w == 0) ? a0 : a1) - BASE;
            e_fwd      = (off < 32'd8192) && w[e_w];
            e_rom_req  = e_fwd;
            e_addr     = off[12:2];
        end
        e_rv = '0;
        if (pend_valid) e_rv[pend_owner] = 1'b1;
        e_opc   = pend_valid && pend_err;
        e_rdata = pend_valid ? pend_data : 32'h0;
    endtask

    function automatic void commit();
        pend_valid = (e_w >= 0);
        if (e_w >= 0) begin
            pend_owner = e_w;
            pend_err   = !e_fwd;
            pend_data  = e_fwd ? mem[e_addr] : 32'h0;
            ptr_m      = (e_w + 1) % NB;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        apply(2'b00, 32'h0, 32'h0, 2'b11);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply(2'b00, 32'h0, 32'h0, 2'b11);
        @(posedge clk_i);
        commit();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        model_reset();
        apply(2'b00, 32'h0, 32'h0, 2'b11);
        #1;
        checks++; if (r_valid_o !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", r_valid_o); end
        checks++; if (r_opc_o !== 1'b0) begin failures++; $display("FAIL reset_opc got=%b exp=0", r_opc_o); end
        checks++; if (r_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", r_rdata_o); end
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt_o); end
        checks++; if (rom_req_o !== 1'b0) begin failures++; $display("FAIL reset_romreq got=%b exp=0", rom_req_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply(2'b00, 32'h0, 32'h0, 2'b11);
        @(posedge clk_i);
        commit();
        @(negedge clk_i);
        apply(2'b00, 32'h0, 32'h0, 2'b11);
        #1;
        checks++; if (r_valid_o !== 2'b00) begin failures++; $display("FAIL idle_rvalid got=%b exp=00", r_valid_o); end
        @(posedge clk_i);
        commit();
    endtask

    task automatic test_single_read();
        @(negedge clk_i);
        apply(2'b01, 32'h1A00_0010, 32'h0, 2'b11);
        #1;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", gnt_o); end
        checks++; if (rom_req_o !== 1'b1) begin failures++; $display("FAIL single_romreq got=%b exp=1", rom_req_o); end
        checks++; if (rom_addr_o !== 11'd4) begin failures++; $display("FAIL single_romaddr got=%h exp=4", rom_addr_o); end
        @(posedge clk_i);
        commit();
        @(negedge clk_i);
        apply(2'b00, 32'h0, 32'h0, 2'b11);
        #1;
        checks++; if (r_valid_o !== 2'b01) begin failures++; $display("FAIL single_rvalid got=%b exp=01", r_valid_o); end
        checks++; if (r_rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", r_rdata_o); end
        checks++; if (r_opc_o !== 1'b0) begin failures++; $display("FAIL single_opc got=%b exp=0", r_opc_o); end
        @(posedge clk_i);
        commit();
    endtask

    task automatic test_contention();
        logic [1:0] seq [4];
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (i < 4) apply(2'b11, BASE + 32'(4 * i), BASE + 32'(64 + 4 * i), 2'b11);
            else       apply(2'b00, 32'h0, 32'h0, 2'b11);
            #1;
            if (i < 4) begin
                checks++; if (gnt_o !== seq[i]) begin failures++; $display("FAIL contention_gnt[%0d] got=%b exp=%b", i, gnt_o, seq[i]); end
            end
            checks++; if (r_valid_o !== e_rv) begin failures++; $display("FAIL contention_rvalid[%0d] got=%b exp=%b", i, r_valid_o, e_rv); end
            checks++; if (r_rdata_o !== e_rdata) begin failures++; $display("FAIL contention_rdata[%0d] got=%h exp=%h", i, r_rdata_o, e_rdata); end
            @(posedge clk_i);
            commit();
        end
    endtask

    task automatic test_write();
        @(negedge clk_i);
        apply(2'b10, 32'h0, BASE + 32'h40, 2'b01);
        #1;
        checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL write_gnt got=%b exp=10", gnt_o); end
        checks++; if (rom_req_o !== 1'b0) begin failures++; $display("FAIL write_romreq got=%b exp=0", rom_req_o); end
        @(posedge clk_i);
        commit();
        @(negedge clk_i);
        apply(2'b00, 32'h0, 32'h0, 2'b11);
        #1;
        checks++; if (r_valid_o !== 2'b10) begin failures++; $display("FAIL write_rvalid got=%b exp=10", r_valid_o); end
        checks++; if (r_opc_o !== 1'b1) begin failures++; $display("FAIL write_opc got=%b exp=1", r_opc_o); end
        checks++; if (r_rdata_o !== 32'h0) begin failures++; $display("FAIL write_rdata got=%h exp=0", r_rdata_o); end
        @(posedge clk_i);
        commit();
    endtask

    task automatic test_range();
        logic [31:0] addr [3];
        logic        fw   [3];
        addr[0] = 32'h1A00_1FFC; fw[0] = 1'b1;
        addr[1] = 32'h1A00_2000; fw[1] = 1'b0;
        addr[2] = 32'h19FF_FFFC; fw[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (i < 3) apply(2'b01, addr[i], 32'h0, 2'b11);
            else       apply(2'b00, 32'h0, 32'h0, 2'b11);
            #1;
            if (i < 3) begin
                checks++; if (rom_req_o !== fw[i]) begin failures++; $display("FAIL range_romreq[%0d] got=%b exp=%b", i, rom_req_o, fw[i]); end
            end
            if (i == 0) begin
                checks++; if (rom_addr_o !== 11'h7FF) begin failures++; $display("FAIL range_romaddr got=%h exp=7ff", rom_addr_o); end
            end
            if (i > 0) begin
                checks++; if (r_opc_o !== !fw[i-1]) begin failures++; $display("FAIL range_opc[%0d] got=%b exp=%b", i, r_opc_o, !fw[i-1]); end
                checks++; if (r_rdata_o !== e_rdata) begin failures++; $display("FAIL range_rdata[%0d] got=%h exp=%h", i, r_rdata_o, e_rdata); end
            end
            @(posedge clk_i);
            commit();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (i < 3) apply(2'b01, BASE + 32'(4 * i), 32'h0, 2'b11);
            else       apply(2'b00, 32'h0, 32'h0, 2'b11);
            #1;
            if (i > 0) begin
                checks++; if (r_valid_o !== 2'b01) begin failures++; $display("FAIL b2b_rvalid[%0d] got=%b exp=01", i, r_valid_o); end
                checks++; if (r_rdata_o !== mem[i-1]) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, r_rdata_o, mem[i-1]); end
            end
            @(posedge clk_i);
            commit();
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk_i);
        apply(2'b01, BASE + 32'h20, 32'h0, 2'b11);
        #1;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL areset_gnt got=%b exp=01", gnt_o); end
        @(posedge clk_i);
        commit();
        #2;
        rst_ni = 1'b0;
        model_reset();
        apply(2'b00, 32'h0, 32'h0, 2'b11);
        #1;
        checks++; if (r_valid_o !== 2'b00) begin failures++; $display("FAIL areset_rvalid got=%b exp=00", r_valid_o); end
        checks++; if (r_opc_o !== 1'b0) begin failures++; $display("FAIL areset_opc got=%b exp=0", r_opc_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply(2'b00, 32'h0, 32'h0, 2'b11);
        @(posedge clk_i);
        commit();
        @(negedge clk_i);
        apply(2'b11, BASE + 32'h4, BASE + 32'h8, 2'b11);
        #1;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL areset_first_gnt got=%b exp=01", gnt_o); end
        checks++; if (r_valid_o !== 2'b00) begin failures++; $display("FAIL areset_spurious got=%b exp=00", r_valid_o); end
        @(posedge clk_i);
        commit();
        @(negedge clk_i);
        apply(2'b00, 32'h0, 32'h0, 2'b11);
        #1;
        checks++; if (r_rdata_o !== mem[1]) begin failures++; $display("FAIL areset_rdata got=%h exp=%h", r_rdata_o, mem[1]); end
        @(posedge clk_i);
        commit();
    endtask

    task automatic test_random();
        logic [31:0] a [2];
        logic [1:0]  w;
        logic [1:0]  r;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            r = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 4))
                    0, 1, 2: a[k] = BASE + 32'($urandom_range(0, 8191));
                    3:       a[k] = BASE + 32'd8192 + 32'($urandom_range(0, 4095));
                    default: a[k] = BASE - 32'd1 - 32'($urandom_range(0, 255));
                endcase
                w[k] = ($urandom_range(0, 3) != 0);
            end
            apply(r, a[0], a[1], w);
            #1;
            checks++; if (gnt_o !== e_gnt) begin failures++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", i, gnt_o, e_gnt); end
            checks++; if (rom_req_o !== e_rom_req) begin failures++; $display("FAIL rand_romreq[%0d] got=%b exp=%b", i, rom_req_o, e_rom_req); end
            if (e_rom_req) begin
                checks++; if (rom_addr_o !== e_addr) begin failures++; $display("FAIL rand_romaddr[%0d] got=%h exp=%h", i, rom_addr_o, e_addr); end
            end
            checks++; if (r_valid_o !== e_rv) begin failures++; $display("FAIL rand_rvalid[%0d] got=%b exp=%b", i, r_valid_o, e_rv); end
            checks++; if (r_opc_o !== e_opc) begin failures++; $display("FAIL rand_opc[%0d] got=%b exp=%b", i, r_opc_o, e_opc); end
            checks++; if (r_rdata_o !== e_rdata) begin failures++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, r_rdata_o, e_rdata); end
            @(posedge clk_i);
            commit();
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        req_i    = '0;
        add_i    = '0;
        wen_i    = 2'b11;
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        mem[4] = 32'hDEAD_BEEF;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_range();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
